// File: rtl/bg_noise_pkg.sv
// Shared types, default widths and saturation bounds for the background-noise estimator.
package bg_noise_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } bg_state_e;

  localparam int BG_NCH    = 16;
  localparam int BG_DW     = 8;
  localparam int BG_ACC_W  = 16;
  localparam int BG_LOG2_N = 4;

  function automatic int acc_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int acc_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/bg_sat_add.sv
// One-channel saturating add of a signed sample into a signed accumulator.
module bg_sat_add
  import bg_noise_pkg::*;
#(
  parameter int DW    = BG_DW,
  parameter int ACC_W = BG_ACC_W
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [DW-1:0]    sample,
  output logic signed [ACC_W-1:0] sum,
  output logic                    clamp
);

  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(acc_max(ACC_W));
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(acc_min(ACC_W));

  logic [ACC_W:0] wide;

  always_comb begin
    wide  = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - DW){sample[DW-1]}}, sample};
    // One guard bit: overflow shows as a disagreement between the top two bits.
    clamp = wide[ACC_W] != wide[ACC_W-1];
    if (!clamp) begin
      sum = wide[ACC_W-1:0];
    end else if (wide[ACC_W]) begin
      sum = MIN_V;
    end else begin
      sum = MAX_V;
    end
  end

endmodule

// File: rtl/bg_noise_accum.sv
// Multi-period background-noise estimator: accumulates 2^LOG2_N periods per channel
// with saturation, then publishes the floored per-channel average on a valid/ready port.
module bg_noise_accum
  import bg_noise_pkg::*;
#(
  parameter int NCH    = BG_NCH,
  parameter int DW     = BG_DW,
  parameter int ACC_W  = BG_ACC_W,
  parameter int LOG2_N = BG_LOG2_N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 period_valid,
  output logic                 period_ready,
  input  logic [NCH*DW-1:0]    period_data,
  output logic                 noise_valid,
  input  logic                 noise_ready,
  output logic [NCH*ACC_W-1:0] noise_data,
  output logic                 sat_flag
);

  // Handshake: a transfer happens on a rising edge where valid && ready; once valid
  // is raised its payload stays stable until that edge.
  localparam int                CNT_W    = LOG2_N + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'((1 << LOG2_N) - 1);

  bg_state_e               state_q, state_d;
  logic signed [ACC_W-1:0] acc_q [NCH];
  logic signed [ACC_W-1:0] acc_d [NCH];
  logic signed [ACC_W-1:0] sum_w [NCH];
  logic [NCH-1:0]          clamp_w;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sticky_q, sticky_d;
  logic                    noise_valid_q, noise_valid_d;
  logic                    sat_flag_q, sat_flag_d;
  logic [NCH*ACC_W-1:0]    noise_data_q, noise_data_d;
  logic                    accept;
  logic                    last;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    bg_sat_add #(.DW(DW), .ACC_W(ACC_W)) u_sat (
      .acc   (acc_q[gi]),
      .sample(period_data[DW*gi +: DW]),
      .sum   (sum_w[gi]),
      .clamp (clamp_w[gi])
    );
  end

  assign period_ready = (state_q == ACCUM) && !clear;
  assign accept       = period_valid && period_ready;
  assign last         = accept && (cnt_q == LAST_CNT);
  assign noise_valid  = noise_valid_q;
  assign noise_data   = noise_data_q;
  assign sat_flag     = sat_flag_q;

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    sticky_d      = sticky_q;
    noise_valid_d = noise_valid_q;
    noise_data_d  = noise_data_q;
    sat_flag_d    = sat_flag_q;
    case (state_q)
      ACCUM: begin
        if (clear) begin
          for (int i = 0; i < NCH; i++) acc_d[i] = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
        end else if (last) begin
          for (int i = 0; i < NCH; i++) begin
            noise_data_d[ACC_W*i +: ACC_W] = sum_w[i] >>> LOG2_N;
            acc_d[i] = '0;
          end
          sat_flag_d    = sticky_q | (|clamp_w);
          cnt_d         = '0;
          sticky_d      = 1'b0;
          noise_valid_d = 1'b1;
          state_d       = HOLD;
        end else if (accept) begin
          acc_d    = sum_w;
          cnt_d    = cnt_q + CNT_W'(1);
          sticky_d = sticky_q | (|clamp_w);
        end
      end
      HOLD: begin
        // clear is deliberately ignored here: a published estimate is never retracted.
        if (noise_ready) begin
          noise_valid_d = 1'b0;
          state_d       = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ACCUM;
      for (int i = 0; i < NCH; i++) acc_q[i] <= '0;
      cnt_q         <= '0;
      sticky_q      <= 1'b0;
      noise_valid_q <= 1'b0;
      noise_data_q  <= '0;
      sat_flag_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      sticky_q      <= sticky_d;
      noise_valid_q <= noise_valid_d;
      noise_data_q  <= noise_data_d;
      sat_flag_q    <= sat_flag_d;
    end
  end

endmodule

// File: tb/tb_bg_noise_accum.sv
// Scoreboard bench for bg_noise_accum: an integer reference model predicts each published
// estimate and the port handshakes; a negedge monitor compares against the DUT.
module tb_bg_noise_accum;

  localparam int NCH    = 16;
  localparam int DW     = 8;
  localparam int ACC_W  = 9;
  localparam int LOG2_N = 2;
  localparam int N      = 1 << LOG2_N;
  localparam int MAXV   = (1 << (ACC_W - 1)) - 1;
  localparam int MINV   = -(1 << (ACC_W - 1));
  localparam int EW     = NCH * ACC_W + 1;

  logic                 clk;
  logic                 rst;
  logic                 clear;
  logic                 period_valid;
  logic                 period_ready;
  logic [NCH*DW-1:0]    period_data;
  logic                 noise_valid;
  logic                 noise_ready;
  logic [NCH*ACC_W-1:0] noise_data;
  logic                 sat_flag;

  int n_cmp;
  int n_bad;
  bit rand_ready;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_pub;
  int            m_sum[NCH];
  int            m_cnt;
  bit            m_sticky;
  bit            m_hold;
  int            s;
  logic [EW-1:0] e;

  bg_noise_accum #(.NCH(NCH), .DW(DW), .ACC_W(ACC_W), .LOG2_N(LOG2_N)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .period_valid(period_valid),
    .period_ready(period_ready),
    .period_data (period_data),
    .noise_valid (noise_valid),
    .noise_ready (noise_ready),
    .noise_data  (noise_data),
    .sat_flag    (sat_flag)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before 500000");
    $fatal(1);
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout required event", name);
  endtask

  // ---------------- reference model ----------------
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < NCH; ch++) m_sum[ch] = 0;
      m_cnt    = 0;
      m_sticky = 0;
      m_hold   = 0;
      last_pub = '0;
      exp_q.delete();
    end else if (m_hold) begin
      if (noise_ready) m_hold = 0;
    end else if (clear) begin
      for (int ch = 0; ch < NCH; ch++) m_sum[ch] = 0;
      m_cnt    = 0;
      m_sticky = 0;
    end else if (period_valid) begin
      for (int ch = 0; ch < NCH; ch++) begin
        s = m_sum[ch] + $signed(period_data[DW*ch +: DW]);
        if (s > MAXV) begin s = MAXV; m_sticky = 1; end
        if (s < MINV) begin s = MINV; m_sticky = 1; end
        m_sum[ch] = s;
      end
      m_cnt++;
      if (m_cnt == N) begin
        for (int ch = 0; ch < NCH; ch++) begin
          e[ACC_W*ch +: ACC_W] = ACC_W'(m_sum[ch] >>> LOG2_N);
          m_sum[ch] = 0;
        end
        e[EW-1] = m_sticky;
        exp_q.push_back(e);
        m_cnt    = 0;
        m_sticky = 0;
        m_hold   = 1;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("period_ready", EW'(period_ready), EW'(!m_hold && !clear));
      check("noise_valid", EW'(noise_valid), EW'(m_hold));
      if (noise_valid) begin
        if (exp_q.size() == 0) begin
          timeout_fail("unexpected_output");
        end else begin
          check("noise_out", {sat_flag, noise_data}, exp_q[0]);
          if (noise_ready) last_pub = exp_q.pop_front();
        end
      end else begin
        check("held_data", EW'(noise_data), EW'(last_pub[EW-2:0]));
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 noise_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [NCH*DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send_period(input logic [NCH*DW-1:0] d);
    int waited = 0;
    period_data  = d;
    period_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (period_ready && !rst) break;
      waited++;
      if (waited > 100) begin
        timeout_fail("send_period");
        break;
      end
    end
    @(posedge clk);
    #1;
    period_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int waited = 0;
    while (exp_q.size() != 0 || noise_valid) begin
      @(negedge clk);
      waited++;
      if (waited > 100) begin
        timeout_fail("drain");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset_check(input string tag);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check({tag, "_valid"}, EW'(noise_valid), '0);
    check({tag, "_data"}, EW'(noise_data), '0);
    check({tag, "_sat"}, EW'(sat_flag), '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [NCH*DW-1:0] d;

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    rand_ready   = 0;
    rst          = 1'b1;
    clear        = 1'b0;
    period_valid = 1'b0;
    period_data  = '0;
    noise_ready  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", EW'(noise_valid), '0);
    check("rst_data", EW'(noise_data), '0);
    check("rst_sat", EW'(sat_flag), '0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_ready", EW'(period_ready), EW'(1));

    // All channels +10.
    repeat (N) send_period({NCH{8'sd10}});
    wait_drain();

    // Floor toward -inf on channel 0, most-negative samples on channel 1.
    for (int k = 0; k < N; k++) begin
      d = rand_data();
      d[7:0]  = (k == 0) ? 8'hFE : 8'hFF;
      d[15:8] = 8'h80;
      send_period(d);
    end
    wait_drain();

    // Positive saturation on channel 3, then a clean zero estimate.
    for (int k = 0; k < N; k++) begin
      d = '0;
      d[31:24] = 8'd127;
      send_period(d);
    end
    repeat (N) send_period('0);
    wait_drain();

    // Backpressure with a pending period.
    noise_ready = 1'b0;
    repeat (N) send_period(rand_data());
    period_valid = 1'b1;
    period_data  = rand_data();
    repeat (5) @(posedge clk);
    #1 noise_ready = 1'b1;
    @(posedge clk);
    #1 period_valid = 1'b0;
    wait_drain();

    // Clear mid-estimate with period_valid high.
    repeat (2) send_period({NCH{8'sd100}});
    clear        = 1'b1;
    period_valid = 1'b1;
    @(posedge clk);
    #1;
    clear        = 1'b0;
    period_valid = 1'b0;
    repeat (N) send_period({NCH{8'sd4}});
    wait_drain();

    // Random data, random consumer stalls, occasional clear pulses.
    rand_ready = 1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        clear        = 1'b1;
        period_valid = 1'($urandom_range(0, 1));
        period_data  = rand_data();
        @(posedge clk);
        #1;
        clear        = 1'b0;
        period_valid = 1'b0;
      end
      send_period(rand_data());
    end
    @(posedge clk);
    rand_ready = 0;
    #2 noise_ready = 1'b1;
    wait_drain();

    // Async reset mid-estimate, then while holding an unconsumed output.
    repeat (3) send_period(rand_data());
    async_reset_check("rst_mid");
    noise_ready = 1'b0;
    repeat (N) send_period({NCH{8'sd20}});
    async_reset_check("rst_hold");
    noise_ready = 1'b1;
    repeat (N) send_period(rand_data());
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
